// File: rtl/key_pkg.sv
// Shared helpers for the key debouncer: ms-to-cycles conversion, idle-level
// helper, the per-channel event record and the counter-width macro.
`ifndef KEY_PKG_SV
`define KEY_PKG_SV

`define KEY_CNT_W(n) (((n) > 1) ? $clog2(n) : 1)

package key_pkg;

  typedef struct packed {
    logic level;
    logic press;
    logic rel;
    logic lng;
  } key_evt_t;

  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

  function automatic logic idle_level(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

endpackage

`endif

// File: rtl/key_debounce_ch.sv
// One key channel: 2-FF synchroniser, debounce counter, stable level and
// press/release pulses; long-press hold counter when KEY_DEBOUNCE_LONG_PRESS_EN is defined.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DB_CYCLES  = 8,
  parameter int LP_CYCLES  = 32,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic     sys_clk,
  input  logic     sys_rst_n,
  input  logic     i_key,
  output key_evt_t o_evt
);

  localparam logic            IDLE    = idle_level(ACTIVE_LOW);
  localparam int              DB_W    = `KEY_CNT_W(DB_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_value;
  logic            r_press;
  logic            r_rel;
  logic [DB_W-1:0] r_db_cnt;
  logic            w_differ;
  logic            w_commit;
  logic            w_long;

  assign w_differ = (r_sync2 != r_value);
  assign w_commit = w_differ && (r_db_cnt == DB_LAST);

  // Any sample matching the stable level restarts the stability window.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sync1  <= IDLE;
      r_sync2  <= IDLE;
      r_value  <= IDLE;
      r_db_cnt <= '0;
      r_press  <= 1'b0;
      r_rel    <= 1'b0;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
      if (!w_differ || w_commit) begin
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
      if (w_commit) begin
        r_value <= r_sync2;
      end
      r_press <= w_commit && (r_sync2 != IDLE);
      r_rel   <= w_commit && (r_sync2 == IDLE);
    end
  end

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
  localparam int              LP_W    = `KEY_CNT_W(LP_CYCLES + 1);
  localparam logic [LP_W-1:0] LP_LAST = LP_W'(LP_CYCLES - 1);
  localparam logic [LP_W-1:0] LP_SAT  = LP_W'(LP_CYCLES);

  logic [LP_W-1:0] r_hold;
  logic            r_long;
  logic            w_held;

  assign w_held = (r_value != IDLE);

  // Counter is zero on the press edge (level still idle) and parks at LP_SAT
  // after firing, so each press yields at most one pulse.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_hold <= '0;
      r_long <= 1'b0;
    end else begin
      r_long <= w_held && (r_hold == LP_LAST);
      if (!w_held) begin
        r_hold <= '0;
      end else if (r_hold != LP_SAT) begin
        r_hold <= r_hold + LP_W'(1);
      end
    end
  end

  assign w_long = r_long;
`else
  logic w_unused_lp;
  assign w_unused_lp = (LP_CYCLES > 0);
  assign w_long      = 1'b0;
`endif

  assign o_evt = '{level: r_value, press: r_press, rel: r_rel, lng: w_long};

endmodule

// File: rtl/key_debounce_multi.sv
// N-channel key debouncer with press/release pulses and optional long-press
// pulses (KEY_DEBOUNCE_LONG_PRESS_EN); channels are fully independent.
module key_debounce_multi
  import key_pkg::*;
#(
  parameter int NUM_KEYS      = 4,
  parameter int CLK_FREQ_HZ   = 50_000_000,
  parameter int DEBOUNCE_MS   = 20,
  parameter int LONG_PRESS_MS = 1000,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [NUM_KEYS-1:0] key,
  output logic [NUM_KEYS-1:0] key_value,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long
);

  localparam int DB_CYCLES = ms_to_cycles(CLK_FREQ_HZ, DEBOUNCE_MS);
  localparam int LP_CYCLES = ms_to_cycles(CLK_FREQ_HZ, LONG_PRESS_MS);

  key_evt_t w_evt [NUM_KEYS];

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DB_CYCLES (DB_CYCLES),
      .LP_CYCLES (LP_CYCLES),
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_ch (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .i_key    (key[g]),
      .o_evt    (w_evt[g])
    );

    assign key_value[g]   = w_evt[g].level;
    assign key_press[g]   = w_evt[g].press;
    assign key_release[g] = w_evt[g].rel;
    assign key_long[g]    = w_evt[g].lng;
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi: directed latency/glitch/reset sequences, a
// vector table and randomized toggling checked against a window-based model.
module tb_key_debounce_multi;

  localparam int NK = 4;
  localparam int DB = 8;
  localparam int LP = 32;
  localparam int LAT = DB + 2;
  localparam int W = 4 * NK;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] key = '1;
  logic [NK-1:0] key_value, key_press, key_release, key_long;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int press_cnt = 0;
  int rel_cnt = 0;
  int long_cnt = 0;

  logic [W-1:0] exp_q[$];

  // Reference model: level flips once DB consecutive synchronised samples
  // (raw delayed by two clocks) disagree with it and DB clocks passed since the last flip.
  logic [NK-1:0] hist [DB+2];
  logic [NK-1:0] m_val, m_press, m_rel, m_long;
  int  m_age [NK];
  int  p_age [NK];
  bit  p_act [NK];

  key_debounce_multi #(
    .NUM_KEYS     (NK),
    .CLK_FREQ_HZ  (8000),
    .DEBOUNCE_MS  (1),
    .LONG_PRESS_MS(4),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .sys_clk    (clk),
    .sys_rst_n  (rst_n),
    .key        (key),
    .key_value  (key_value),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  always #5 clk = ~clk;

  function automatic int popc(input logic [NK-1:0] v);
    int c = 0;
    for (int i = 0; i < NK; i++) c += int'(v[i]);
    return c;
  endfunction

  function automatic logic [NK-1:0] sel(input int kind);
    case (kind)
      0:       return key_press;
      1:       return key_release;
      default: return key_long;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic model_step();
    bit all_diff;
    m_press = '0;
    m_rel   = '0;
    m_long  = '0;
    if (!rst_n) begin
      for (int j = 0; j < DB + 2; j++) hist[j] = '1;
      m_val = '1;
      for (int k = 0; k < NK; k++) begin
        m_age[k] = DB;
        p_age[k] = 0;
        p_act[k] = 1'b0;
      end
      return;
    end
    for (int j = DB + 1; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = key;
    for (int k = 0; k < NK; k++) begin
      if (m_age[k] < 100000) m_age[k]++;
      if (p_act[k]) begin
        p_age[k]++;
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
        if (p_age[k] == LP) m_long[k] = 1'b1;
`endif
      end
      all_diff = 1'b1;
      for (int j = 2; j < DB + 2; j++) if (hist[j][k] == m_val[k]) all_diff = 1'b0;
      if (all_diff && m_age[k] >= DB) begin
        m_val[k] = ~m_val[k];
        m_age[k] = 0;
        if (m_val[k] == 1'b0) begin
          m_press[k] = 1'b1;
          p_act[k]   = 1'b1;
          p_age[k]   = 0;
        end else begin
          m_rel[k] = 1'b1;
          p_act[k] = 1'b0;
        end
      end
    end
  endtask

  // One clock: advance the model at the edge, compare the DUT 1 ns later.
  task automatic step();
    logic [W-1:0] got;
    logic [W-1:0] exp;
    @(posedge clk);
    model_step();
    exp_q.push_back({m_val, m_press, m_rel, m_long});
    #1;
    cyc++;
    got = {key_value, key_press, key_release, key_long};
    exp = exp_q.pop_front();
    check("model", 32'(got), 32'(exp));
    press_cnt += popc(key_press);
    rel_cnt   += popc(key_release);
    long_cnt  += popc(key_long);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_evt(input int kind, input int b, input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      step();
      if (sel(kind)[b]) begin
        n = i;
        break;
      end
    end
  endtask

  typedef struct {
    logic [NK-1:0] key;
    int            cycles;
    logic [NK-1:0] exp_val;
    int            exp_press;
    int            exp_rel;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int n, pb, rb, lb, hold;

    tbl[0]  = '{4'hF, 12,     4'hF, 0, 0};
    tbl[1]  = '{4'hE, 12,     4'hE, 1, 0};
    tbl[2]  = '{4'hF, 12,     4'hF, 0, 1};
    tbl[3]  = '{4'hD, DB - 1, 4'hF, 0, 0};
    tbl[4]  = '{4'hF, 12,     4'hF, 0, 0};
    tbl[5]  = '{4'h6, 12,     4'h6, 2, 0};
    tbl[6]  = '{4'hF, 12,     4'hF, 0, 2};
    tbl[7]  = '{4'h0, 12,     4'h0, 4, 0};
    tbl[8]  = '{4'hF, 12,     4'hF, 0, 4};
    tbl[9]  = '{4'hB, LAT - 1, 4'hF, 0, 0};
    tbl[10] = '{4'hB, 1,      4'hB, 1, 0};
    tbl[11] = '{4'hF, 12,     4'hF, 0, 1};

    // Reset state
    rst_n = 1'b0;
    key   = '1;
    steps(3);
    check("rst_value", 32'(key_value), 32'hF);
    check("rst_pulses", 32'({key_press, key_release, key_long}), 32'h0);
    rst_n = 1'b1;
    steps(2);

    // Clean press on key 0
    pb = press_cnt;
    key[0] = 1'b0;
    wait_evt(0, 0, 20, n);
    check("press0_latency", 32'(n), 32'(LAT));
    steps(15);
    check("press0_once", 32'(press_cnt - pb), 32'd1);
    check("press0_level", 32'(key_value[0]), 32'd0);
    key[0] = 1'b1;
    steps(12);

    // Repeated DB-1 glitches on key 1, then a real press
    pb = press_cnt;
    rb = rel_cnt;
    for (int g = 0; g < 5; g++) begin
      key[1] = 1'b0;
      steps(DB - 1);
      key[1] = 1'b1;
      steps(3);
    end
    check("glitch_level", 32'(key_value[1]), 32'd1);
    check("glitch_pulses", 32'((press_cnt - pb) + (rel_cnt - rb)), 32'd0);
    key[1] = 1'b0;
    wait_evt(0, 1, 20, n);
    check("glitch_press_latency", 32'(n), 32'(LAT));
    steps(5);
    check("glitch_press_once", 32'(press_cnt - pb), 32'd1);
    key[1] = 1'b1;
    steps(12);

    // Short hold on key 2: release pulse, no long press
    key[2] = 1'b0;
    wait_evt(0, 2, 20, n);
    check("press2_latency", 32'(n), 32'(LAT));
    lb = long_cnt;
    steps(20);
    key[2] = 1'b1;
    wait_evt(1, 2, 20, n);
    check("release2_latency", 32'(n), 32'(LAT));
    steps(40);
    check("short_hold_no_long", 32'(long_cnt - lb), 32'd0);

    // Long hold on key 3
    key[3] = 1'b0;
    wait_evt(0, 3, 20, n);
    check("press3_latency", 32'(n), 32'(LAT));
    lb = long_cnt;
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    wait_evt(2, 3, 40, n);
    check("long3_latency", 32'(n), 32'(LP));
    steps(30);
    check("long3_once", 32'(long_cnt - lb), 32'd1);
`else
    steps(60);
    check("long3_absent", 32'(long_cnt - lb), 32'd0);
`endif
    key[3] = 1'b1;
    steps(12);

    // Simultaneous press on keys 0 and 3
    key = 4'b0110;
    wait_evt(0, 0, 20, n);
    check("simul_latency", 32'(n), 32'(LAT));
    check("simul_vector", 32'(key_press), 32'h9);
    key = '1;
    steps(12);

    // Reset mid-debounce with key 1 held
    key[1] = 1'b0;
    steps(7);
    rst_n = 1'b0;
    step();
    check("midrst_value", 32'(key_value), 32'hF);
    check("midrst_pulses", 32'({key_press, key_release, key_long}), 32'h0);
    steps(2);
    rst_n = 1'b1;
    rb = rel_cnt;
    wait_evt(0, 1, 20, n);
    check("midrst_press_latency", 32'(n), 32'(LAT));
    check("midrst_no_release", 32'(rel_cnt - rb), 32'd0);
    key[1] = 1'b1;
    steps(12);

    // Vector table
    for (int i = 0; i < 12; i++) begin
      pb  = press_cnt;
      rb  = rel_cnt;
      key = tbl[i].key;
      steps(tbl[i].cycles);
      check($sformatf("tbl%0d_level", i), 32'(key_value), 32'(tbl[i].exp_val));
      check($sformatf("tbl%0d_press", i), 32'(press_cnt - pb), 32'(tbl[i].exp_press));
      check($sformatf("tbl%0d_release", i), 32'(rel_cnt - rb), 32'(tbl[i].exp_rel));
    end

    // Randomized toggling with occasional long holds and resets
    for (int it = 0; it < 200; it++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        steps(2);
        rst_n = 1'b1;
      end
      key  = key ^ NK'($urandom_range(0, 15));
      hold = ($urandom_range(0, 7) == 0) ? int'($urandom_range(30, 45))
                                         : int'($urandom_range(1, 12));
      steps(hold);
    end
    key = '1;
    steps(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
